// File: rtl/inst_mem_if.sv
// Fetch/response/preload bundle between an instruction requester (master) and
// inst_mem_server (slave).
interface inst_mem_if #(
  parameter int DEPTH_LOG2 = 10
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable from valid until that edge.
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  load_en;
  logic [DEPTH_LOG2-1:0] load_idx;
  logic [31:0]           load_data;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_idx, load_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/inst_mem_server.sv
// Single-outstanding instruction memory responder with configurable latency.
// Optional INST_MEM_RAND_DELAY_EN adds an LFSR-driven 0..3 cycle extra delay.
module inst_mem_server #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  inst_mem_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int         WORDS  = 1 << DEPTH_LOG2;
  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic [31:0] mem [WORDS];

  logic [4:0]  extra;
  logic [4:0]  load_val;
  logic [31:0] cap_addr;
  logic [31:0] cap_off;
  logic        cap_err;
  logic [31:0] cap_data;

`ifdef INST_MEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign extra = {3'b000, lfsr[1:0]};
`else
  assign extra = 5'd0;
`endif

  assign load_val = LAT_M1 + extra;

  // A zero-delay accept captures straight from the bus address; otherwise the
  // capture happens in WAIT from the latched copy.
  assign cap_addr = (state == IDLE) ? bus.req_addr : addr_q;
  assign cap_off  = cap_addr - BASE_ADDR;
  assign cap_err  = (cap_addr[1:0] != 2'b00) || ((cap_off >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign cap_data = cap_err ? 32'h0 : mem[cap_off[DEPTH_LOG2+1:2]];

  always_ff @(posedge clk) begin
    if (bus.load_en) mem[bus.load_idx] <= bus.load_data;
  end

  // cnt counts the edges still to pass before the capture edge; the capture
  // happens on the edge that takes it from 1 to 0, so rsp_valid rises exactly
  // LATENCY(+extra) edges after the accept edge, counting the accept itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      addr_q     <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            if (load_val == 5'd0) begin
              rsp_data_q <= cap_data;
              rsp_err_q  <= cap_err;
              state      <= RESP;
            end else begin
              cnt   <= load_val;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            rsp_data_q <= cap_data;
            rsp_err_q  <= cap_err;
            state      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state     = state;
endmodule
